// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared definitions for the two-port memory arbiter.
//   - FSM state encoding (ARB_IDLE / ARB_OWN / ARB_DRAIN)
//   - port ids (PORT_I, PORT_D)
//   - ctr_width(): width of the outstanding-read counter
package mem_arb_pkg;

    localparam logic [1:0] ARB_IDLE  = 2'd0;
    localparam logic [1:0] ARB_OWN   = 2'd1;
    localparam logic [1:0] ARB_DRAIN = 2'd2;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    // One extra bit so the counter can hold MAX_OUTSTANDING itself.
    function automatic int ctr_width(input int max_out);
        return $clog2(max_out) + 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bus bundle between the two caches, the arbiter and memory.
//   pi_* : instruction-cache port (req/ren/wen/addr/wdata in, ready/rdata/valid out)
//   pd_* : data-cache port, same shape
//   mem_*: backing memory (addr/ren/wen/wdata out, ready/rdata/valid in)
//   err  : sticky protocol error
// Modports: slave = arbiter view, master = caches + memory view.
interface mem_arbiter_if;
    logic        pi_req, pi_ren, pi_wen;
    logic [31:0] pi_addr, pi_wdata;
    logic        pi_ready, pi_valid;
    logic [31:0] pi_rdata;

    logic        pd_req, pd_ren, pd_wen;
    logic [31:0] pd_addr, pd_wdata;
    logic        pd_ready, pd_valid;
    logic [31:0] pd_rdata;

    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ren, mem_wen;
    logic        mem_ready, mem_valid;
    logic [31:0] mem_rdata;

    logic        err;

    modport slave (
        input  pi_req, pi_ren, pi_wen, pi_addr, pi_wdata,
        output pi_ready, pi_valid, pi_rdata,
        input  pd_req, pd_ren, pd_wen, pd_addr, pd_wdata,
        output pd_ready, pd_valid, pd_rdata,
        output mem_addr, mem_wdata, mem_ren, mem_wen,
        input  mem_ready, mem_valid, mem_rdata,
        output err
    );

    modport master (
        output pi_req, pi_ren, pi_wen, pi_addr, pi_wdata,
        input  pi_ready, pi_valid, pi_rdata,
        output pd_req, pd_ren, pd_wen, pd_addr, pd_wdata,
        input  pd_ready, pd_valid, pd_rdata,
        input  mem_addr, mem_wdata, mem_ren, mem_wen,
        output mem_ready, mem_valid, mem_rdata,
        input  err
    );
endinterface

// File: rtl/mem_arb_outstanding_ctr.sv
// mem_arb_outstanding_ctr: up/down counter of reads accepted by memory but
// not yet answered.
//   i_clk, i_rst : clock, synchronous active-high reset
//   inc          : read accepted this cycle
//   dec          : response returned this cycle (ignored when empty)
//   count        : current count
//   full / empty : count == MAX_OUTSTANDING / count == 0
//   empty_next   : count will be 0 after this edge
module mem_arb_outstanding_ctr
    import mem_arb_pkg::*;
#(
    parameter  int MAX_OUTSTANDING = 4,
    localparam int CW = ctr_width(MAX_OUTSTANDING)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          inc,
    input  logic          dec,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic          empty_next
);
    logic [CW-1:0] count_next;
    logic          dec_eff;

    // A response with nothing outstanding is spurious and must not underflow.
    assign dec_eff = dec & ~empty;

    always_comb begin
        count_next = count;
        if (inc && !dec_eff)      count_next = count + CW'(1);
        else if (!inc && dec_eff) count_next = count - CW'(1);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) count <= '0;
        else       count <= count_next;
    end

    assign full       = (count == CW'(MAX_OUTSTANDING));
    assign empty      = (count == '0);
    assign empty_next = (count_next == '0);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one word-granular memory port between the I-cache and
// the D-cache. One owner at a time; its beats pass straight to memory and
// in-order read responses are routed back to it. Ownership only moves once
// every outstanding read of the owner has returned.
//   i_clk, i_rst : clock, synchronous active-high reset
//   bus          : mem_arbiter_if.slave (cache ports, memory port, err)
// Build option: ARB_FIXED_PRIO_EN -- ties always go to port D instead of
// round-robin; the round-robin pointer then stays at its reset value.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    mem_arbiter_if.slave  bus
);
    localparam int CW = ctr_width(MAX_OUTSTANDING);

    logic [1:0]    state, state_nx;
    logic          owner, owner_nx;   // current owner port id
    logic          ptr, ptr_nx;       // last owner; the other side wins a tie
    logic          err, err_set;
    logic          rel;

    logic          own_req, own_ren, own_wen, other_req;
    logic [31:0]   own_addr, own_wdata;
    logic          own_rdy, rd_acc, wr_acc, route;

    logic [CW-1:0] count;
    logic          full, empty, empty_next;

    assign own_req   = (owner == PORT_D) ? bus.pd_req   : bus.pi_req;
    assign own_ren   = (owner == PORT_D) ? bus.pd_ren   : bus.pi_ren;
    assign own_wen   = (owner == PORT_D) ? bus.pd_wen   : bus.pi_wen;
    assign own_addr  = (owner == PORT_D) ? bus.pd_addr  : bus.pi_addr;
    assign own_wdata = (owner == PORT_D) ? bus.pd_wdata : bus.pi_wdata;
    assign other_req = (owner == PORT_D) ? bus.pi_req   : bus.pd_req;

    // Ready depends only on state, counter and memory ready; a full counter
    // withholds ready, which is what saturates the count.
    assign own_rdy = (state == ARB_OWN) & bus.mem_ready & ~full & ~i_rst;
    assign rd_acc  = own_rdy & own_ren;
    assign wr_acc  = own_rdy & own_wen & ~own_ren;   // read wins a collision

    assign err_set = (own_rdy & own_ren & own_wen) | (bus.mem_valid & empty);

    mem_arb_outstanding_ctr #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_ctr (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .inc        (rd_acc),
        .dec        (bus.mem_valid),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .empty_next (empty_next)
    );

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ARB_IDLE;
            owner <= PORT_I;
            ptr   <= PORT_D;      // "last owner was D" so I wins the first tie
            err   <= 1'b0;
        end else begin
            state <= state_nx;
            owner <= owner_nx;
            ptr   <= ptr_nx;
            err   <= err | err_set;
        end
    end

    // Next state. Release is judged on the post-edge count so a port that
    // drains on its last response hands over on the very next cycle.
    always_comb begin
        state_nx = state;
        owner_nx = owner;
        ptr_nx   = ptr;
        rel      = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (bus.pi_req || bus.pd_req) begin
                    state_nx = ARB_OWN;
`ifdef ARB_FIXED_PRIO_EN
                    owner_nx = bus.pd_req ? PORT_D : PORT_I;
`else
                    owner_nx = (bus.pi_req && bus.pd_req) ? ~ptr
                             : (bus.pd_req ? PORT_D : PORT_I);
`endif
                end
            end
            ARB_OWN: begin
                if (!own_req) begin
                    if (empty_next) rel      = 1'b1;
                    else            state_nx = ARB_DRAIN;
                end
            end
            ARB_DRAIN: begin
                if (empty_next) rel = 1'b1;
            end
            default: state_nx = ARB_IDLE;
        endcase

        if (rel) begin
`ifndef ARB_FIXED_PRIO_EN
            ptr_nx = owner;
`endif
            if (other_req) begin
                state_nx = ARB_OWN;
                owner_nx = ~owner;
`ifdef ARB_FIXED_PRIO_EN
                // A D owner that re-raised req during drain keeps the tie.
                if (owner == PORT_D && own_req) owner_nx = PORT_D;
`endif
            end else begin
                state_nx = ARB_IDLE;
            end
        end
    end

    // Outputs
    always_comb begin
        route         = (state != ARB_IDLE) & ~i_rst;
        bus.pi_ready  = own_rdy & (owner == PORT_I);
        bus.pd_ready  = own_rdy & (owner == PORT_D);
        bus.mem_ren   = rd_acc;
        bus.mem_wen   = wr_acc;
        bus.mem_addr  = (state == ARB_OWN && !i_rst) ? own_addr  : '0;
        bus.mem_wdata = (state == ARB_OWN && !i_rst) ? own_wdata : '0;
        // Responses with nothing outstanding are dropped.
        bus.pi_valid  = route & bus.mem_valid & ~empty & (owner == PORT_I);
        bus.pd_valid  = route & bus.mem_valid & ~empty & (owner == PORT_D);
        bus.pi_rdata  = (route && owner == PORT_I) ? bus.mem_rdata : '0;
        bus.pd_rdata  = (route && owner == PORT_D) ? bus.mem_rdata : '0;
        bus.err       = err;
    end

endmodule
